sobel_window_gen: RTL

- Streaming 3x3 window generator that sits directly upstream of the Sobel gradient/magnitude stage.
- Accepts one 8-bit grayscale pixel per handshake in raster order (row 0 col 0 first) for a WIDTH x HEIGHT frame.
- Emits one 3x3 neighbourhood per interior pixel, tagged with output coordinates, so the downstream stage writes results into a (WIDTH-2) x (HEIGHT-2) output image.
- Replaces whole-frame memory scanning with two line buffers.

---
 rtl/sobel_pkg.sv | 20 ++
 rtl/sobel_line_buffer.sv | 60 ++++++
 rtl/sobel_window_gen.sv | 138 +++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sobel_pkg
// Brief    : Shared pixel/window types and window indexing for the 3x3 stage.
// Revision : 1.0
// ============================================================================
package sobel_pkg;

    localparam int PIX_W = 8;

    typedef logic [PIX_W-1:0] pix_t;
    typedef pix_t [8:0]       win_t;

    // Row r = 0 is the oldest row, column c = 0 is the leftmost column.
    function automatic int win_idx(input int r, input int c);
        return r * 3 + c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : sobel_line_buffer
// Brief    : Two cascaded line RAMs (row-1, row-2) sharing one address.
// Revision : 1.0
// ============================================================================
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int WIDTH    = 240,
    parameter int PIX_W    = 8,
    parameter int AW       = $clog2(WIDTH),
    parameter bit REG_READ = 1'b0
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [AW-1:0]    i_next_addr,
    input  logic [PIX_W-1:0] i_wdata,
    output logic [PIX_W-1:0] o_rd0,
    output logic [PIX_W-1:0] o_rd1
);

    logic [PIX_W-1:0] r_mem0 [WIDTH];
    logic [PIX_W-1:0] r_mem1 [WIDTH];
    logic [PIX_W-1:0] w_rd0;
    logic [PIX_W-1:0] w_rd1;

    generate
        if (REG_READ == 1'b0) begin : g_comb_read
            logic w_unused_next;
            assign w_unused_next = ^i_next_addr;
            assign w_rd0 = r_mem0[i_addr];
            assign w_rd1 = r_mem1[i_addr];
        end else begin : g_reg_read
            // The caller presents the address it will use next cycle; it never
            // equals the address being written, so no bypass is required.
            logic [PIX_W-1:0] r_rd0;
            logic [PIX_W-1:0] r_rd1;
            always_ff @(posedge clk) begin
                r_rd0 <= r_mem0[i_next_addr];
                r_rd1 <= r_mem1[i_next_addr];
            end
            assign w_rd0 = r_rd0;
            assign w_rd1 = r_rd1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem0[i_addr] <= i_wdata;
            r_mem1[i_addr] <= w_rd0;
        end
    end

    assign o_rd0 = w_rd0;
    assign o_rd1 = w_rd1;

endmodule
`default_nettype wire

// File: rtl/sobel_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : sobel_window_gen
// Brief    : Streaming 3x3 neighbourhood generator feeding the Sobel stage.
// Revision : 1.0
// ============================================================================
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int WIDTH       = 240,
    parameter int HEIGHT      = 240,
    parameter int PIX_W       = sobel_pkg::PIX_W,
    parameter int XW          = $clog2(WIDTH),
    parameter int YW          = $clog2(HEIGHT),
    parameter bit LB_REG_READ = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PIX_W-1:0]   in_pix,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [9*PIX_W-1:0] out_win,
    output logic [XW-1:0]      out_x,
    output logic [YW-1:0]      out_y,
    output logic               frame_done
);

    localparam logic [XW-1:0] c_col_last = XW'(WIDTH - 1);
    localparam logic [YW-1:0] c_row_last = YW'(HEIGHT - 1);

    logic [XW-1:0]      r_col;
    logic [YW-1:0]      r_row;
    logic [6*PIX_W-1:0] r_tail;
    logic               r_out_valid;
    logic [9*PIX_W-1:0] r_out_win;
    logic [XW-1:0]      r_out_x;
    logic [YW-1:0]      r_out_y;
    logic               r_frame_done;

    logic               w_accept;
    logic               w_emit;
    logic               w_col_wrap;
    logic [XW-1:0]      w_next_col;
    logic [PIX_W-1:0]   w_lb0;
    logic [PIX_W-1:0]   w_lb1;
    logic [3*PIX_W-1:0] w_col_in;
    logic [9*PIX_W-1:0] w_win_next;
    logic [6*PIX_W-1:0] w_tail_next;

    assign in_ready   = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_col_wrap = (r_col == c_col_last);
    assign w_emit     = (r_row >= YW'(2)) && (r_col >= XW'(2));

    always_comb begin
        w_next_col = r_col;
        if (rst) begin
            w_next_col = '0;
        end else if (w_accept) begin
            w_next_col = w_col_wrap ? '0 : r_col + XW'(1);
        end
    end

    sobel_line_buffer #(
        .WIDTH    (WIDTH),
        .PIX_W    (PIX_W),
        .AW       (XW),
        .REG_READ (LB_REG_READ)
    ) u_line_buffer (
        .clk         (clk),
        .i_we        (w_accept),
        .i_addr      (r_col),
        .i_next_addr (w_next_col),
        .i_wdata     (in_pix),
        .o_rd0       (w_lb0),
        .o_rd1       (w_lb1)
    );

    // Incoming column, indexed by window row: row-2, row-1, current pixel.
    assign w_col_in = {in_pix, w_lb0, w_lb1};

    generate
        for (genvar r = 0; r < 3; r++) begin : g_row
            assign w_win_next[win_idx(r, 0)*PIX_W +: PIX_W] = r_tail[(r*2)*PIX_W +: PIX_W];
            assign w_win_next[win_idx(r, 1)*PIX_W +: PIX_W] = r_tail[(r*2+1)*PIX_W +: PIX_W];
            assign w_win_next[win_idx(r, 2)*PIX_W +: PIX_W] = w_col_in[r*PIX_W +: PIX_W];
            assign w_tail_next[(r*2)*PIX_W +: PIX_W]   = w_win_next[win_idx(r, 1)*PIX_W +: PIX_W];
            assign w_tail_next[(r*2+1)*PIX_W +: PIX_W] = w_win_next[win_idx(r, 2)*PIX_W +: PIX_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_tail       <= '0;
            r_out_valid  <= 1'b0;
            r_out_win    <= '0;
            r_out_x      <= '0;
            r_out_y      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_accept) begin
                r_tail <= w_tail_next;
                r_col  <= w_next_col;
                if (w_col_wrap) begin
                    if (r_row == c_row_last) begin
                        r_row        <= '0;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_row <= r_row + YW'(1);
                    end
                end
            end
            // A fresh window can only be loaded when the held one is consumed,
            // because accepting requires in_ready.
            if (w_accept && w_emit) begin
                r_out_valid <= 1'b1;
                r_out_win   <= w_win_next;
                r_out_x     <= r_col - XW'(2);
                r_out_y     <= r_row - YW'(2);
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_win    = r_out_win;
    assign out_x      = r_out_x;
    assign out_y      = r_out_y;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
